// File: rtl/cmos_power_pkg.sv
// Shared state encoding and timing defaults for the camera power-on/power-off sequencers.
package cmos_power_pkg;

   localparam int CNT_W             = 20;
   localparam int DEF_DRAIN_TIMEOUT = 24000;
   localparam int DEF_T_RST_CYC     = 1024;
   localparam int DEF_T_OFF_CYC     = 24000;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_RST     = 3'd2,
      ST_PWDN    = 3'd3,
      ST_OFF     = 3'd4,
      ST_RESTART = 3'd5
   } pd_state_e;

   // Terminal count for a stay of 'cycles' clocks; the counter starts at zero on entry.
   function automatic logic [CNT_W-1:0] last_count(input int cycles);
      return CNT_W'(cycles - 32'sd1);
   endfunction

endpackage

// File: rtl/camera_power_off_seq.sv
// Camera power-down sequencer: overrides the power-on sequencer's pins to drain SCCB,
// assert reset, then power down, and restarts the power-on sequencer on release.
module camera_power_off_seq
   import cmos_power_pkg::*;
#(
   parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
   parameter int T_RST_CYC     = DEF_T_RST_CYC,
   parameter int T_OFF_CYC     = DEF_T_OFF_CYC
) (
   input  logic clk_24M,
   input  logic reset,
   input  logic pd_req,
   input  logic sccb_busy,
   input  logic up_rstn,
   input  logic up_pwnd,
   input  logic up_initial_en,
   output logic camera_rstn,
   output logic camera_pwnd,
   output logic initial_en,
   output logic on_seq_rstn,
   output logic pd_done
);

   localparam logic [CNT_W-1:0] DRAIN_LAST = last_count(DRAIN_TIMEOUT);
   localparam logic [CNT_W-1:0] RST_LAST   = last_count(T_RST_CYC);
   localparam logic [CNT_W-1:0] OFF_LAST   = last_count(T_OFF_CYC);

   pd_state_e        state_r;
   pd_state_e        state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             rstn_s;
   logic             pwnd_s;
   logic             init_s;
   logic             seq_rstn_s;
   logic             done_s;

   // Next-state, shared counter and pin values for the current state.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      rstn_s     = up_rstn;
      pwnd_s     = up_pwnd;
      init_s     = up_initial_en;
      seq_rstn_s = 1'b1;
      done_s     = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (pd_req) begin
               state_s = ST_DRAIN;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            init_s = 1'b0;
            if (!sccb_busy || (cnt_r == DRAIN_LAST)) begin
               state_s = ST_RST;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_RST: begin
            rstn_s = 1'b0;
            pwnd_s = 1'b0;
            init_s = 1'b0;
            if (cnt_r == RST_LAST) begin
               state_s = ST_PWDN;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_PWDN: begin
            rstn_s = 1'b0;
            pwnd_s = 1'b1;
            init_s = 1'b0;
            if (cnt_r == OFF_LAST) begin
               state_s = ST_OFF;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_OFF: begin
            rstn_s = 1'b0;
            pwnd_s = 1'b1;
            init_s = 1'b0;
            done_s = 1'b1;
            if (!pd_req) begin
               state_s = ST_RESTART;
            end else begin
               state_s = ST_OFF;
            end
         end
         ST_RESTART: begin
            // Pulsing the power-on sequencer's reset makes it replay its full bring-up timing.
            seq_rstn_s = 1'b0;
            rstn_s     = 1'b0;
            pwnd_s     = 1'b1;
            init_s     = 1'b0;
            state_s    = ST_RUN;
         end
         default: begin
            state_s = ST_RUN;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // State, counter and registered pin outputs.
   always_ff @(posedge clk_24M) begin
      if (reset) begin
         state_r     <= ST_RUN;
         cnt_r       <= CNT_ZERO;
         camera_rstn <= 1'b0;
         camera_pwnd <= 1'b1;
         initial_en  <= 1'b0;
         on_seq_rstn <= 1'b1;
         pd_done     <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         camera_rstn <= rstn_s;
         camera_pwnd <= pwnd_s;
         initial_en  <= init_s;
         on_seq_rstn <= seq_rstn_s;
         pd_done     <= done_s;
      end
   end

endmodule

// File: tb/tb_camera_power_off_seq.sv
// Self-checking bench for camera_power_off_seq against a timeline-based reference model.
module tb_camera_power_off_seq;

   localparam int DT = 8;
   localparam int TR = 4;
   localparam int TO = 6;

   logic clk_24M = 1'b0;
   logic reset = 1'b1;
   logic pd_req = 1'b0;
   logic sccb_busy = 1'b0;
   logic up_rstn = 1'b0;
   logic up_pwnd = 1'b0;
   logic up_initial_en = 1'b0;
   logic camera_rstn, camera_pwnd, initial_en, on_seq_rstn, pd_done;

   wire [4:0] obs = {camera_rstn, camera_pwnd, initial_en, on_seq_rstn, pd_done};

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: where the sequence stands, measured as time since it started.
   bit       m_in_seq = 1'b0;
   bit       m_restart = 1'b0;
   int       m_elapsed = 0;
   int       m_drain_len = 0;
   logic [4:0] exp_out = 5'b01010;

   camera_power_off_seq #(
      .DRAIN_TIMEOUT(DT),
      .T_RST_CYC(TR),
      .T_OFF_CYC(TO)
   ) dut (
      .clk_24M(clk_24M),
      .reset(reset),
      .pd_req(pd_req),
      .sccb_busy(sccb_busy),
      .up_rstn(up_rstn),
      .up_pwnd(up_pwnd),
      .up_initial_en(up_initial_en),
      .camera_rstn(camera_rstn),
      .camera_pwnd(camera_pwnd),
      .initial_en(initial_en),
      .on_seq_rstn(on_seq_rstn),
      .pd_done(pd_done)
   );

   always #5 clk_24M = ~clk_24M;

   // Expected registered outputs after the coming edge; vector is {rstn, pwnd, init, on_seq_rstn, done}.
   task automatic model_step();
      if (reset) begin
         exp_out   = 5'b01010;
         m_in_seq  = 1'b0;
         m_restart = 1'b0;
      end else if (m_restart) begin
         exp_out   = 5'b01000;
         m_restart = 1'b0;
      end else if (!m_in_seq) begin
         exp_out = {up_rstn, up_pwnd, up_initial_en, 1'b1, 1'b0};
         if (pd_req) begin
            m_in_seq    = 1'b1;
            m_elapsed   = 0;
            m_drain_len = 0;
         end
      end else if (m_drain_len == 0) begin
         exp_out = {up_rstn, up_pwnd, 1'b0, 1'b1, 1'b0};
         if (!sccb_busy || m_elapsed == DT - 1) m_drain_len = m_elapsed + 1;
         m_elapsed++;
      end else if (m_elapsed < m_drain_len + TR) begin
         exp_out = 5'b00010;
         m_elapsed++;
      end else if (m_elapsed < m_drain_len + TR + TO) begin
         exp_out = 5'b01010;
         m_elapsed++;
      end else begin
         exp_out = 5'b01011;
         if (!pd_req) begin
            m_in_seq  = 1'b0;
            m_restart = 1'b1;
         end
      end
   endtask

   task automatic tick(input logic r, input logic pd, input logic busy,
                       input logic ur, input logic upw, input logic ui);
      reset = r; pd_req = pd; sccb_busy = busy;
      up_rstn = ur; up_pwnd = upw; up_initial_en = ui;
      model_step();
      @(negedge clk_24M);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         n_cmp++;
         if (obs !== 5'b01010) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want %b", obs, 5'b01010);
         end
      end
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         n_cmp++;
         if (obs !== exp_out) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", obs, exp_out);
         end
      end
   endtask

   task automatic test_drain_idle();
      int drain_c = 0, rst_c = 0, pwdn_c = 0;
      tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
         n_cmp++;
         if (obs !== exp_out) begin
            n_fail++;
            $display("FAIL drain_idle cyc%0d: got %b want %b", i, obs, exp_out);
         end
         if (camera_rstn && !initial_en) drain_c++;
         if (!camera_rstn && !camera_pwnd) rst_c++;
         if (camera_pwnd && !pd_done && on_seq_rstn) pwdn_c++;
      end
      n_cmp++;
      if (drain_c !== 1) begin n_fail++; $display("FAIL drain_idle_len: got %0d want 1", drain_c); end
      n_cmp++;
      if (rst_c !== TR) begin n_fail++; $display("FAIL rst_low_len: got %0d want %0d", rst_c, TR); end
      n_cmp++;
      if (pwdn_c !== TO) begin n_fail++; $display("FAIL pwdn_len: got %0d want %0d", pwdn_c, TO); end
      n_cmp++;
      if (pd_done !== 1'b1) begin n_fail++; $display("FAIL off_done: got %b want 1", pd_done); end
   endtask

   task automatic test_drain_timeout();
      int drain_c = 0;
      tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 24; i++) begin
         tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
         n_cmp++;
         if (obs !== exp_out) begin
            n_fail++;
            $display("FAIL drain_timeout cyc%0d: got %b want %b", i, obs, exp_out);
         end
         if (camera_rstn && !initial_en) drain_c++;
      end
      n_cmp++;
      if (drain_c !== DT) begin n_fail++; $display("FAIL timeout_len: got %0d want %0d", drain_c, DT); end
   endtask

   task automatic test_restart();
      int low_c = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         n_cmp++;
         if (obs !== exp_out) begin
            n_fail++;
            $display("FAIL restart cyc%0d: got %b want %b", i, obs, exp_out);
         end
         if (!on_seq_rstn) low_c++;
      end
      n_cmp++;
      if (low_c !== 1) begin n_fail++; $display("FAIL restart_pulse: got %0d want 1", low_c); end
   endtask

   task automatic test_pulse();
      int pwnd_c = 0;
      int low_c = 0;
      tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 25; i++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         n_cmp++;
         if (obs !== exp_out) begin
            n_fail++;
            $display("FAIL pulse cyc%0d: got %b want %b", i, obs, exp_out);
         end
         if (!on_seq_rstn) low_c++;
         if (camera_pwnd && on_seq_rstn && low_c == 0) pwnd_c++;
      end
      n_cmp++;
      if (low_c !== 1) begin n_fail++; $display("FAIL pulse_restart: got %0d want 1", low_c); end
      n_cmp++;
      if (pwnd_c < TO) begin n_fail++; $display("FAIL pulse_pwnd_min: got %0d want >= %0d", pwnd_c, TO); end
   endtask

   task automatic test_back_to_back();
      int low_c = 0;
      int rerun = 0;
      tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
         n_cmp++;
         if (obs !== exp_out) begin
            n_fail++;
            $display("FAIL back_to_back cyc%0d: got %b want %b", i, obs, exp_out);
         end
         if (!on_seq_rstn) low_c++;
         if (low_c == 1 && !camera_rstn && !camera_pwnd) rerun = 1;
      end
      n_cmp++;
      if (low_c !== 1) begin n_fail++; $display("FAIL b2b_restart: got %0d want 1", low_c); end
      n_cmp++;
      if (rerun !== 1) begin n_fail++; $display("FAIL b2b_rerun: got %0d want 1", rerun); end
   endtask

   task automatic test_reset_mid();
      tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (obs !== 5'b01010) begin n_fail++; $display("FAIL mid_in_pwdn: got %b want %b", obs, 5'b01010); end
      tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if ({on_seq_rstn, pd_done} !== 2'b10) begin
         n_fail++;
         $display("FAIL mid_reset: got %b want %b", {on_seq_rstn, pd_done}, 2'b10);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
         n_cmp++;
         if (obs !== exp_out) begin
            n_fail++;
            $display("FAIL mid_passthru cyc%0d: got %b want %b", i, obs, exp_out);
         end
      end
   endtask

   task automatic test_random();
      logic pd = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 15) == 0) pd = ~pd;
         tick(($urandom_range(0, 127) == 0), pd, ($urandom_range(0, 3) != 0),
              1'($urandom), 1'($urandom), 1'($urandom));
         n_cmp++;
         if (obs !== exp_out) begin
            n_fail++;
            $display("FAIL random cyc%0d: got %b want %b", i, obs, exp_out);
         end
      end
   endtask

   initial begin
      @(negedge clk_24M);
      test_reset();
      test_drain_idle();
      test_drain_timeout();
      test_restart();
      test_pulse();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/camera_power_off_seq.md
CAMERA_POWER_OFF_SEQ -- requirements
Module: camera_power_off_seq

Interface
REQ-001 SHALL have parameter DRAIN_TIMEOUT, default 24000, max clk_24M cycles spent waiting for SCCB idle (1 ms at 24 MHz).
REQ-002 SHALL have parameter T_RST_CYC, default 1024, cycles camera_rstn is held low before camera_pwnd rises.
REQ-003 SHALL have parameter T_OFF_CYC, default 24000, minimum cycles camera_pwnd is held high before restart is allowed.
REQ-004 SHALL have port clk_24M  input  1  sole clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pd_req  input  1  level; 1 = request camera power-down, 0 = request camera run.
REQ-007 SHALL have port sccb_busy  input  1  1 while an SCCB transaction is in flight.
REQ-008 SHALL have ports up_rstn, up_pwnd, up_initial_en  input  1 each  outputs of the power-on sequencer.
REQ-009 SHALL have ports camera_rstn, camera_pwnd, initial_en  output  1 each  pin-level signals after override.
REQ-010 SHALL have port on_seq_rstn  output  1  active-low restart to the power-on sequencer reset_n.
REQ-011 SHALL have port pd_done  output  1  1 while the camera is fully powered down.

Function
REQ-012 SHALL implement FSM states RUN, DRAIN, RST, PWDN, OFF, RESTART, with one shared 20-bit counter.
REQ-013 In RUN: camera_rstn=up_rstn, camera_pwnd=up_pwnd, initial_en=up_initial_en, on_seq_rstn=1, pd_done=0; pd_req=1 -> DRAIN next cycle, counter cleared.
REQ-014 In DRAIN: initial_en=0, camera_rstn=up_rstn, camera_pwnd=up_pwnd; sccb_busy=0 or counter=DRAIN_TIMEOUT-1 -> RST, counter cleared; otherwise counter increments.
REQ-015 In RST: camera_rstn=0, camera_pwnd=0, initial_en=0; counter=T_RST_CYC-1 -> PWDN, counter cleared.
REQ-016 In PWDN: camera_rstn=0, camera_pwnd=1, initial_en=0; counter=T_OFF_CYC-1 -> OFF.
REQ-017 In OFF: camera_rstn=0, camera_pwnd=1, initial_en=0, pd_done=1; pd_req=0 -> RESTART.
REQ-018 In RESTART (exactly 1 cycle): on_seq_rstn=0, camera_rstn=0, camera_pwnd=1, initial_en=0, pd_done=0; -> RUN.
REQ-019 After RESTART, pin outputs SHALL follow the power-on sequencer again, which re-runs its full pwnd/rstn/initial_en timing.
REQ-020 pd_req deasserting during DRAIN/RST/PWDN SHALL NOT abort the sequence; OFF is entered and left on the next cycle.
REQ-021 pd_req reasserting in RESTART SHALL be ignored until RUN; in RUN, it SHALL start DRAIN on the following cycle.
REQ-022 All outputs SHALL be registered; output changes appear the cycle after the state transition.
REQ-023 Counter SHALL never wrap; each compare uses parameter-1, so a parameter value of 1 gives a one-cycle stay.

Reset
REQ-024 reset=1 SHALL force state RUN, counter 0, on_seq_rstn=1, pd_done=0, initial_en=0, camera_rstn=0, camera_pwnd=1 in the registered outputs; pass-through resumes the first cycle after reset.
REQ-025 reset asserted in any state, including mid-sequence, SHALL take effect on the next clk_24M edge, with no partial sequence resumed.

Structure
REQ-026 State encoding and default timing constants SHALL live in shared package cmos_power_pkg, also usable by the power-on sequencer.
REQ-027 SHALL be a single module; no sub-module.

Verification (DRAIN_TIMEOUT=8, T_RST_CYC=4, T_OFF_CYC=6)
REQ-028 Idle, pd_req=1, sccb_busy=0 -> DRAIN 1 cycle; camera_rstn low 4 cycles before camera_pwnd=1; pd_done=1 after 6 more cycles.
REQ-029 pd_req=1 with sccb_busy held 1 -> RST entered after exactly 8 DRAIN cycles (timeout path); initial_en=0 from first DRAIN cycle.
REQ-030 In OFF, pd_req=0 -> single-cycle on_seq_rstn=0 pulse, pd_done=0, then outputs equal up_* inputs.
REQ-031 pd_req pulsed 1 for one cycle -> full sequence to OFF, then immediate RESTART; at least 6 cycles of camera_pwnd=1 elapse before restart.
REQ-032 reset asserted during PWDN -> next cycle state RUN, pd_done=0, on_seq_rstn=1; pass-through on the first post-reset cycle.
